map_collision_scanner: RTL and testbench

Consumer of the packed level geometry (`info_ground[16]` and `info_fence[16]`, 29-bit entries) produced by the world-map block. On a `start` pulse it latches a proposed player move and walks all 16 ground/fence entry pairs, one pair per cycle. It reports the first ground segment the player's feet cross and the first fence the leading edge crosses. It sits between the world-map block and the player-motion logic, and is run once per frame.

---
 rtl/map_collision_scanner_if.sv | 38 +++
 rtl/map_collision_scanner.sv | 197 +++++++++++++++++++
 tb/tb_map_collision_scanner.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/map_collision_scanner_if.sv
// rtl/map_collision_scanner_if.sv - move request and collision result bundle for map_collision_scanner
interface map_collision_scanner_if #(
  parameter int N_ENT = 16
);
  localparam int IW = $clog2(N_ENT);

  logic          start;
  logic [9:0]    box_x0;
  logic [9:0]    box_x1;
  logic [8:0]    box_y0;
  logic [8:0]    box_y1;
  logic [8:0]    foot_y_cur;
  logic [8:0]    foot_y_next;
  logic [9:0]    lead_x_cur;
  logic [9:0]    lead_x_next;
  logic          dir_left;

  logic          busy;
  logic          done;
  logic          land_hit;
  logic [8:0]    land_y;
  logic [IW-1:0] land_idx;
  logic          wall_hit;
  logic [9:0]    wall_x;
  logic [IW-1:0] wall_idx;

  modport master (
    output start, box_x0, box_x1, box_y0, box_y1,
           foot_y_cur, foot_y_next, lead_x_cur, lead_x_next, dir_left,
    input  busy, done, land_hit, land_y, land_idx, wall_hit, wall_x, wall_idx
  );

  modport slave (
    input  start, box_x0, box_x1, box_y0, box_y1,
           foot_y_cur, foot_y_next, lead_x_cur, lead_x_next, dir_left,
    output busy, done, land_hit, land_y, land_idx, wall_hit, wall_x, wall_idx
  );
endinterface

// File: rtl/map_collision_scanner.sv
// rtl/map_collision_scanner.sv - sequential ground/fence crossing search over packed level geometry
module map_collision_scanner #(
  parameter int N_ENT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [28:0] info_ground [N_ENT],
  input  logic [28:0] info_fence  [N_ENT],
  map_collision_scanner_if.slave bus
);
  localparam int IW = $clog2(N_ENT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ENT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;

  logic [9:0]    bx0, bx1;
  logic [8:0]    by0, by1;
  logic [8:0]    fyc, fyn;
  logic [9:0]    lxc, lxn;
  logic          dl;

  logic          acc_land_hit;
  logic [8:0]    acc_land_y;
  logic [IW-1:0] acc_land_idx;
  logic          acc_wall_hit;
  logic [9:0]    acc_wall_x;
  logic [IW-1:0] acc_wall_idx;

  logic          busy_q, done_q;
  logic          land_hit_q, wall_hit_q;
  logic [8:0]    land_y_q;
  logic [9:0]    wall_x_q;
  logic [IW-1:0] land_idx_q, wall_idx_q;

  logic [28:0]   g_ent, f_ent;
  logic [9:0]    g_x, g_len;
  logic [8:0]    g_y;
  logic [10:0]   g_end;
  logic          g_match, g_take;
  logic [8:0]    f_y;
  logic [9:0]    f_x, f_len, f_end;
  logic          f_span, f_match, f_take;

  logic          nxt_land_hit, nxt_wall_hit;
  logic [8:0]    nxt_land_y;
  logic [9:0]    nxt_wall_x;
  logic [IW-1:0] nxt_land_idx, nxt_wall_idx;

  // Map entries are static, so the current pair is read straight from the live inputs.
  always_comb begin
    g_ent   = info_ground[idx];
    g_x     = g_ent[9:0];
    g_y     = g_ent[18:10];
    g_len   = g_ent[28:19];
    g_end   = {1'b0, g_x} + {1'b0, g_len};
    g_match = (g_len != 10'd0) &&
              (bx1 >= g_x) &&
              ({1'b0, bx0} <= g_end) &&
              (fyc <= g_y) && (g_y <= fyn);
    g_take  = g_match && (!acc_land_hit || (g_y < acc_land_y));

    f_ent   = info_fence[idx];
    f_y     = f_ent[8:0];
    f_x     = f_ent[18:9];
    f_len   = f_ent[28:19];
    f_end   = {1'b0, f_y} + f_len;
    f_span  = dl ? ((lxn <= f_x) && (f_x <= lxc))
                 : ((lxc <= f_x) && (f_x <= lxn));
    f_match = (f_len != 10'd0) &&
              (by1 >= f_y) &&
              ({1'b0, by0} <= f_end) &&
              (lxc != lxn) && f_span;
    // The nearest fence in the direction of travel wins; ties keep the earlier index.
    f_take  = f_match && (!acc_wall_hit ||
                          (dl ? (f_x > acc_wall_x) : (f_x < acc_wall_x)));

    nxt_land_hit = acc_land_hit;
    nxt_land_y   = acc_land_y;
    nxt_land_idx = acc_land_idx;
    if (g_take) begin
      nxt_land_hit = 1'b1;
      nxt_land_y   = g_y;
      nxt_land_idx = idx;
    end

    nxt_wall_hit = acc_wall_hit;
    nxt_wall_x   = acc_wall_x;
    nxt_wall_idx = acc_wall_idx;
    if (f_take) begin
      nxt_wall_hit = 1'b1;
      nxt_wall_x   = f_x;
      nxt_wall_idx = idx;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      idx          <= '0;
      bx0          <= '0;
      bx1          <= '0;
      by0          <= '0;
      by1          <= '0;
      fyc          <= '0;
      fyn          <= '0;
      lxc          <= '0;
      lxn          <= '0;
      dl           <= 1'b0;
      acc_land_hit <= 1'b0;
      acc_land_y   <= '0;
      acc_land_idx <= '0;
      acc_wall_hit <= 1'b0;
      acc_wall_x   <= '0;
      acc_wall_idx <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      land_hit_q   <= 1'b0;
      land_y_q     <= '0;
      land_idx_q   <= '0;
      wall_hit_q   <= 1'b0;
      wall_x_q     <= '0;
      wall_idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bx0          <= bus.box_x0;
            bx1          <= bus.box_x1;
            by0          <= bus.box_y0;
            by1          <= bus.box_y1;
            fyc          <= bus.foot_y_cur;
            fyn          <= bus.foot_y_next;
            lxc          <= bus.lead_x_cur;
            lxn          <= bus.lead_x_next;
            dl           <= bus.dir_left;
            idx          <= '0;
            acc_land_hit <= 1'b0;
            acc_land_y   <= '0;
            acc_land_idx <= '0;
            acc_wall_hit <= 1'b0;
            acc_wall_x   <= '0;
            acc_wall_idx <= '0;
            busy_q       <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          acc_land_hit <= nxt_land_hit;
          acc_land_y   <= nxt_land_y;
          acc_land_idx <= nxt_land_idx;
          acc_wall_hit <= nxt_wall_hit;
          acc_wall_x   <= nxt_wall_x;
          acc_wall_idx <= nxt_wall_idx;
          idx          <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            // Results include the final entry, so load from the next-state values.
            land_hit_q <= nxt_land_hit;
            land_y_q   <= nxt_land_y;
            land_idx_q <= nxt_land_idx;
            wall_hit_q <= nxt_wall_hit;
            wall_x_q   <= nxt_wall_x;
            wall_idx_q <= nxt_wall_idx;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.land_hit = land_hit_q;
  assign bus.land_y   = land_y_q;
  assign bus.land_idx = land_idx_q;
  assign bus.wall_hit = wall_hit_q;
  assign bus.wall_x   = wall_x_q;
  assign bus.wall_idx = wall_idx_q;
endmodule

// File: tb/tb_map_collision_scanner.sv
// tb/tb_map_collision_scanner.sv - directed self-checking bench for map_collision_scanner
module tb_map_collision_scanner;
  logic        Clk;
  logic        Reset;
  logic [28:0] info_ground [16];
  logic [28:0] info_fence  [16];
  int          n_checks;
  int          n_errors;

  map_collision_scanner_if bus ();

  map_collision_scanner dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .info_ground(info_ground),
    .info_fence (info_fence),
    .bus        (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] gnd(input int x, input int y, input int len);
    logic [9:0] xv, lv;
    logic [8:0] yv;
    xv = x[9:0];
    yv = y[8:0];
    lv = len[9:0];
    return {lv, yv, xv};
  endfunction

  function automatic logic [28:0] fnc(input int y, input int x, input int len);
    logic [9:0] xv, lv;
    logic [8:0] yv;
    xv = x[9:0];
    yv = y[8:0];
    lv = len[9:0];
    return {lv, xv, yv};
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 16; i++) begin
      info_ground[i] = '0;
      info_fence[i]  = '0;
    end
  endtask

  task automatic load_base_map();
    clear_map();
    info_ground[0] = gnd(0, 430, 639);
    info_ground[1] = gnd(100, 380, 120);
    info_fence[0]  = fnc(382, 102, 48);
    info_fence[4]  = fnc(382, 219, 48);
  endtask

  task automatic set_move(input int bx0, input int bx1, input int by0, input int by1,
                          input int fyc, input int fyn, input int lxc, input int lxn,
                          input logic dl);
    bus.box_x0      = bx0[9:0];
    bus.box_x1      = bx1[9:0];
    bus.box_y0      = by0[8:0];
    bus.box_y1      = by1[8:0];
    bus.foot_y_cur  = fyc[8:0];
    bus.foot_y_next = fyn[8:0];
    bus.lead_x_cur  = lxc[9:0];
    bus.lead_x_next = lxn[9:0];
    bus.dir_left    = dl;
  endtask

  // Start on a negedge; lat counts posedges since (and including) the start edge.
  task automatic do_scan();
    int lat;
    int bcnt;
    @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge Clk);
      lat++;
    end
    check("latency", lat, 17);
    check("busy_cycles", bcnt, 16);
    check("busy_at_done", bus.busy, 0);
    @(negedge Clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int dcnt;
    n_checks = 0;
    n_errors = 0;
    Reset    = 1'b0;
    bus.start = 1'b0;
    clear_map();
    set_move(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge Clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_land_hit", bus.land_hit, 0);
    check("rst_land_y", bus.land_y, 0);
    check("rst_land_idx", bus.land_idx, 0);
    check("rst_wall_hit", bus.wall_hit, 0);
    check("rst_wall_x", bus.wall_x, 0);
    check("rst_wall_idx", bus.wall_idx, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Ground landing combined with a rightward wall hit
    load_base_map();
    set_move(150, 170, 390, 420, 370, 385, 100, 225, 1'b0);
    do_scan();
    check("g_land_hit", bus.land_hit, 1);
    check("g_land_y", bus.land_y, 380);
    check("g_land_idx", bus.land_idx, 1);
    check("r_wall_hit", bus.wall_hit, 1);
    check("r_wall_x", bus.wall_x, 102);
    check("r_wall_idx", bus.wall_idx, 0);

    // Leftward move picks the largest x_loc
    set_move(150, 170, 390, 420, 370, 385, 230, 100, 1'b1);
    do_scan();
    check("l_wall_hit", bus.wall_hit, 1);
    check("l_wall_x", bus.wall_x, 219);
    check("l_wall_idx", bus.wall_idx, 4);

    // No horizontal motion never hits a fence
    set_move(150, 170, 390, 420, 370, 385, 150, 150, 1'b1);
    do_scan();
    check("still_wall_hit", bus.wall_hit, 0);
    check("still_land_y", bus.land_y, 380);

    // Tied grounds keep the lower index; non-overlapping lower ground is excluded
    clear_map();
    info_ground[2] = gnd(0, 300, 200);
    info_ground[5] = gnd(0, 300, 200);
    info_ground[7] = gnd(0, 305, 200);
    info_ground[9] = gnd(400, 295, 10);
    set_move(50, 60, 0, 10, 290, 310, 0, 0, 1'b0);
    do_scan();
    check("tie_land_hit", bus.land_hit, 1);
    check("tie_land_y", bus.land_y, 300);
    check("tie_land_idx", bus.land_idx, 2);

    // x_start + length must not wrap at 10 bits; standing exactly on y_loc counts
    clear_map();
    info_ground[3] = gnd(1000, 200, 1000);
    set_move(1010, 1020, 0, 10, 200, 200, 0, 0, 1'b0);
    do_scan();
    check("wrap_land_hit", bus.land_hit, 1);
    check("wrap_land_idx", bus.land_idx, 3);

    // box_x0 exactly at the ground's right end still overlaps
    clear_map();
    info_ground[6] = gnd(100, 150, 50);
    set_move(150, 160, 0, 10, 100, 150, 0, 0, 1'b0);
    do_scan();
    check("edge_land_hit", bus.land_hit, 1);
    check("edge_land_y", bus.land_y, 150);
    check("edge_land_idx", bus.land_idx, 6);

    // All-empty map: zero-length entries never match
    clear_map();
    set_move(0, 10, 0, 10, 0, 5, 0, 0, 1'b0);
    do_scan();
    check("empty_land_hit", bus.land_hit, 0);
    check("empty_wall_hit", bus.wall_hit, 0);

    // Start pulsed during busy is ignored and produces a single done
    load_base_map();
    set_move(150, 170, 390, 420, 370, 385, 100, 225, 1'b0);
    @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    dcnt = 0;
    for (int i = 2; i <= 45; i++) begin
      bus.start = (i == 5);
      if (bus.done) dcnt++;
      @(negedge Clk);
    end
    bus.start = 1'b0;
    check("ignored_done_count", dcnt, 1);
    check("ignored_land_y", bus.land_y, 380);
    clear_map();
    set_move(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (10) @(negedge Clk);
    check("held_land_hit", bus.land_hit, 1);
    check("held_land_y", bus.land_y, 380);
    check("held_wall_x", bus.wall_x, 102);

    // Reset mid-scan clears held results immediately and suppresses done
    load_base_map();
    set_move(150, 170, 390, 420, 370, 385, 100, 225, 1'b0);
    @(negedge Clk);
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (7) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_land_hit", bus.land_hit, 0);
    check("abort_land_y", bus.land_y, 0);
    check("abort_wall_hit", bus.wall_hit, 0);
    check("abort_wall_x", bus.wall_x, 0);
    @(negedge Clk);
    Reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dcnt++;
      @(negedge Clk);
    end
    check("abort_no_done", dcnt, 0);
    do_scan();
    check("after_abort_land_y", bus.land_y, 380);
    check("after_abort_wall_idx", bus.wall_idx, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
